fetch_align_stage: RTL and testbench
====================================

Name: fetch_align_stage

Overview:
- Front-end stage that produces the decode-stage inputs: `instruction`, `pc` and `compflg`.
- Issues word-aligned fetches to instruction memory and buffers the returned halfwords.
- Aligns 16-/32-bit instructions, including 32-bit instructions that straddle a word boundary.
- Presents one instruction per cycle to decode over a valid/ready handshake.
- Handles redirects from execute (branch/jump) by flushing its buffer and dropping in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, PC of the first instruction after reset.
- HBUF_DEPTH, 4, halfword buffer depth; must be ≥4 and even.
- MAX_OUTSTANDING, 2, maximum fetch requests in flight.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- fetch_req  out  1  fetch request.
- fetch_addr  out  32  word address, bits[1:0]=0.
- fetch_gnt  in  1  request accepted this cycle.
- fetch_rvalid  in  1  response data valid; responses return in order.
- fetch_rdata  in  32  response word, little-endian halfwords.
- redirect_en  in  1  flush and restart.
- redirect_pc  in  32  new PC, halfword-aligned.
- out_valid  out  1  instruction valid to decode.
- out_ready  in  1  decode accepts.
- instruction  out  32  instruction_type from common.
- pc  out  32  PC of `instruction`.
- compflg  out  1  1 = 16-bit compressed instruction.

Behaviour:

Reset (asynchronous, active-low):
- out_valid=0, instruction=0, pc=RESET_PC, compflg=0, fetch_req=0.
- fetch_addr=RESET_PC&~3; buffer empty; outstanding=0; drop count=0.

Fetch issue:
- fetch_req=1 when (free halfword slots) ≥ 2*(outstanding+1) and outstanding<MAX_OUTSTANDING.
- A request is accepted on fetch_req&fetch_gnt; then fetch_addr+=4 and outstanding++.
- fetch_addr and fetch_req stay stable while fetch_req&!fetch_gnt.

Response:
- On fetch_rvalid: outstanding--.
- If drop count>0, discard the word and decrement drop count.
- Otherwise push halfword[15:0], then halfword[31:16].
- If the skip_low flag is set, push only [31:16] and clear the flag.

Align:
- Head halfword h0.
- With `RVC_EN`, h0[1:0]!=2'b11 means a 16-bit instruction: needs 1 halfword, instruction={16'h0,h0}, compflg=1, pc step 2.
- Otherwise 32-bit: needs 2 halfwords, instruction={h1,h0}, compflg=0, pc step 4.
- If not enough halfwords are buffered, wait; out_valid stays 0.

Output register:
- Loaded when !out_valid | out_ready and an instruction is available.
- The loaded instruction's halfwords are popped in the same cycle.
- Outputs hold stable while out_valid&!out_ready.
- pc increments by the step on each load; there is no bubble at a buffer boundary.
- Latency: first valid output 2 cycles after the first response (push cycle, then load cycle).

Redirect (highest priority):
- In the redirect cycle, buffer cleared and out_valid→0 next edge.
- drop count = outstanding − (fetch_rvalid?1:0); a fetch_rvalid in that same cycle is discarded.
- Any request granted in that cycle is also added to the drop count.
- fetch_addr=redirect_pc&~3; pc next-load value = redirect_pc; skip_low = redirect_pc[1].
- redirect_en with redirect_pc[0]=1 is illegal; the bench asserts on it.

Boundary conditions:
- Buffer full: fetch_req=0.
- Simultaneous push and pop in one cycle is legal.
- Outstanding never exceeds MAX_OUTSTANDING.
- Back-to-back redirects: the later one wins.
- PC wraps modulo 2^32.

Optional Feature:

`RVC_EN`:
- Defined: compressed-instruction detection active as above.
- Undefined:
  - Every instruction is 32-bit and compflg is tied 0.
  - redirect_pc[1] must be 0 (asserted).
  - The halfword buffer degenerates to a word buffer of depth HBUF_DEPTH/2; the skip_low flag is removed.

Decomposition:
- Package common:
  - Existing instruction_type.
  - Localparams: RVC_OPC_MASK=2'b11, PC_STEP_16=2, PC_STEP_32=4.
  - Typedef for the hword type (logic[15:0]).
- Sub-module `fetch_hword_fifo`:
  - Parameter DEPTH.
  - Single push of 1 or 2 halfwords; pop of 1 or 2 halfwords.
  - Exposes count, h0, h1; synchronous flush; same clk/rst_n.

Test Plan:
1. Reset, memory returns 0x00000013 at 0x0, 0x00000013 at 0x4 → decode sees pc=0x0 then 0x4, compflg=0.
2. `RVC_EN`, word 0x4501_4505 at 0x0 → two outputs: instruction=0x0000_4505 pc=0x0 compflg=1, then 0x0000_4501 pc=0x2 compflg=1.
3. Straddle: word@0x0=0x0093_4505, word@0x4=0xAAAA_0010 → 0x4505 (pc 0x0, C), then 0x0010_0093 (pc 0x2, compflg=0).
4. out_ready=0 for 5 cycles with 2 instructions buffered → outputs held stable; fetch_req drops when buffer full; resumes with no lost or duplicated pc.
5. Redirect to 0x100 with 2 responses outstanding → both discarded; next out pc=0x100; fetch_addr=0x100.
6. `RVC_EN`, redirect to 0x102, word@0x100=0x4505_FFFF → first out instruction=0x0000_4505, pc=0x102.

Source files
------------

// File: rtl/common.sv
// common: shared front-end types and constants for the fetch/align stage.
package common;
  typedef logic [31:0] instruction_type;
  typedef logic [15:0] hword_t;
  localparam logic [1:0] RVC_OPC_MASK = 2'b11;
  localparam int PC_STEP_16 = 2;
  localparam int PC_STEP_32 = 4;
endpackage

// File: rtl/fetch_align_stage_fifo.sv
// fetch_hword_fifo: circular halfword buffer, push/pop of 1 or 2 halfwords per cycle, synchronous flush.
module fetch_hword_fifo
  import common::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_flush,
  input  logic          i_push_en,
  input  logic          i_push_two,
  input  hword_t        i_push_d0,
  input  hword_t        i_push_d1,
  input  logic          i_pop_en,
  input  logic          i_pop_two,
  output logic [CW-1:0] o_count,
  output hword_t        o_h0,
  output hword_t        o_h1
);
  hword_t        r_mem [DEPTH];
  logic [AW-1:0] r_rd, r_wr;
  logic [CW-1:0] r_count;
  logic [1:0]    w_push_n, w_pop_n;

  function automatic logic [AW-1:0] adv(input logic [AW-1:0] p, input logic [1:0] n);
    logic [AW:0] s;
    s = (AW+1)'(p) + (AW+1)'(n);
    return (s >= (AW+1)'(DEPTH)) ? AW'(s - (AW+1)'(DEPTH)) : AW'(s);
  endfunction

  always_comb begin
    w_push_n = i_push_en ? (i_push_two ? 2'd2 : 2'd1) : 2'd0;
    w_pop_n  = i_pop_en ? (i_pop_two ? 2'd2 : 2'd1) : 2'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      r_rd    <= adv(r_rd, w_pop_n);
      r_wr    <= adv(r_wr, w_push_n);
      r_count <= r_count + CW'(w_push_n) - CW'(w_pop_n);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push_en && !i_flush) begin
      r_mem[r_wr] <= i_push_d0;
      if (i_push_two) r_mem[adv(r_wr, 2'd1)] <= i_push_d1;
    end
  end

  assign o_count = r_count;
  assign o_h0    = r_mem[r_rd];
  assign o_h1    = r_mem[adv(r_rd, 2'd1)];
endmodule

// File: rtl/fetch_align_stage.sv
// fetch_align_stage: word fetch issue, halfword alignment and valid/ready output to decode.
// Define RVC_EN to enable 16-bit compressed instruction detection and halfword-aligned redirects.
module fetch_align_stage
  import common::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          HBUF_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            fetch_req,
  output logic [31:0]     fetch_addr,
  input  logic            fetch_gnt,
  input  logic            fetch_rvalid,
  input  logic [31:0]     fetch_rdata,
  input  logic            redirect_en,
  input  logic [31:0]     redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output instruction_type instruction,
  output logic [31:0]     pc,
  output logic            compflg
);
  localparam int CW = $clog2(HBUF_DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  logic            r_run, r_out_valid;
  logic [31:0]     r_fetch_addr, r_next_pc, r_pc;
  logic [OW-1:0]   r_outstanding, r_drop;
  instruction_type r_instr;
  logic [CW-1:0]   w_count;
  hword_t          w_h0, w_h1, w_d0;
  logic [31:0]     w_free, w_resv, w_step;
  logic            w_acc, w_push, w_push_two, w_is16, w_load;

`ifdef RVC_EN
  logic r_skip_low, r_compflg;
  assign w_is16     = (w_h0[1:0] & RVC_OPC_MASK) != RVC_OPC_MASK;
  assign w_push_two = !r_skip_low;
  assign w_d0       = r_skip_low ? fetch_rdata[31:16] : fetch_rdata[15:0];
  assign compflg    = r_compflg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skip_low <= RESET_PC[1];
      r_compflg  <= 1'b0;
    end else begin
      if (redirect_en) r_skip_low <= redirect_pc[1];
      else if (w_push) r_skip_low <= 1'b0;
      if (w_load) r_compflg <= w_is16;
    end
  end
`else
  assign w_is16     = 1'b0;
  assign w_push_two = 1'b1;
  assign w_d0       = fetch_rdata[15:0];
  assign compflg    = 1'b0;
`endif

  // each outstanding request reserves a full word of buffer space
  assign w_free    = 32'(HBUF_DEPTH) - 32'(w_count);
  assign w_resv    = (32'(r_outstanding) + 32'd1) << 1;
  assign fetch_req = r_run && w_free >= w_resv && r_outstanding < OW'(MAX_OUTSTANDING);
  assign w_acc     = fetch_req & fetch_gnt;
  assign w_push    = fetch_rvalid && r_drop == '0 && !redirect_en;
  assign w_step    = w_is16 ? 32'(PC_STEP_16) : 32'(PC_STEP_32);
  assign w_load    = !redirect_en && (!r_out_valid || out_ready) && w_count >= (w_is16 ? CW'(1) : CW'(2));

  fetch_hword_fifo #(.DEPTH(HBUF_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_flush   (redirect_en),
    .i_push_en (w_push),
    .i_push_two(w_push_two),
    .i_push_d0 (w_d0),
    .i_push_d1 (fetch_rdata[31:16]),
    .i_pop_en  (w_load),
    .i_pop_two (!w_is16),
    .o_count   (w_count),
    .o_h0      (w_h0),
    .o_h1      (w_h1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run         <= 1'b0;
      r_fetch_addr  <= {RESET_PC[31:2], 2'b00};
      r_outstanding <= '0;
      r_drop        <= '0;
      r_out_valid   <= 1'b0;
      r_instr       <= '0;
      r_pc          <= RESET_PC;
      r_next_pc     <= RESET_PC;
    end else begin
      r_run         <= 1'b1;
      r_outstanding <= r_outstanding + OW'(w_acc) - OW'(fetch_rvalid);
      if (redirect_en) begin
        r_fetch_addr <= {redirect_pc[31:2], 2'b00};
        r_drop       <= r_outstanding + OW'(w_acc) - OW'(fetch_rvalid);
        r_next_pc    <= redirect_pc;
        r_out_valid  <= 1'b0;
      end else begin
        if (w_acc) r_fetch_addr <= r_fetch_addr + 32'd4;
        if (fetch_rvalid && r_drop != '0) r_drop <= r_drop - OW'(1);
        if (w_load) begin
          r_out_valid <= 1'b1;
          r_instr     <= w_is16 ? {16'h0, w_h0} : {w_h1, w_h0};
          r_pc        <= r_next_pc;
          r_next_pc   <= r_next_pc + w_step;
        end else if (out_ready) begin
          r_out_valid <= 1'b0;
        end
      end
    end
  end

  assign fetch_addr  = r_fetch_addr;
  assign out_valid   = r_out_valid;
  assign instruction = r_instr;
  assign pc          = r_pc;
endmodule

// File: tb/tb_fetch_align_stage.sv
// tb_fetch_align_stage: random memory/decode traffic against a PC-walking program model; set RVC_EN to match the DUT build.
module tb_fetch_align_stage;
  import common::*;

`ifdef RVC_EN
  localparam bit RVC = 1'b1;
`else
  localparam bit RVC = 1'b0;
`endif
  localparam int MAX_OUT = 2;

  typedef struct {logic [31:0] ins; logic [31:0] pc; logic c;} exp_t;
  typedef struct {logic [31:0] addr; int due;} req_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            fetch_req, fetch_gnt, fetch_rvalid;
  logic [31:0]     fetch_addr, fetch_rdata;
  logic            redirect_en, out_valid, out_ready, compflg;
  logic [31:0]     redirect_pc, pc;
  instruction_type instruction;

  logic [31:0] mem [1024];
  exp_t        expq [$];
  req_t        pend [$];
  int          checks = 0, errors = 0, handshakes = 0, cyc = 0;
  bit          gnt_rand = 1'b0;
  int          lat_lo = 0, lat_hi = 0;

  fetch_align_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_gnt   (fetch_gnt),
    .fetch_rvalid(fetch_rvalid),
    .fetch_rdata (fetch_rdata),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .instruction (instruction),
    .pc          (pc),
    .compflg     (compflg)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && redirect_en) begin
      assert (redirect_pc[0] == 1'b0);
      if (!RVC) assert (redirect_pc[1] == 1'b0);
    end
  end

  function automatic logic [15:0] hw(input logic [31:0] a);
    logic [31:0] w;
    w = mem[a[11:2]];
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  // walk the program from a PC, one instruction at a time
  task automatic gen(input logic [31:0] start, input int n);
    logic [31:0] p;
    logic [15:0] h;
    p = start;
    for (int i = 0; i < n; i++) begin
      h = hw(p);
      if (RVC && h[1:0] != 2'b11) begin
        expq.push_back('{ins: {16'h0, h}, pc: p, c: 1'b1});
        p = p + 32'd2;
      end else begin
        expq.push_back('{ins: {hw(p + 32'd2), h}, pc: p, c: 1'b0});
        p = p + 32'd4;
      end
    end
  endtask

  task automatic push_exp(input logic [31:0] ins, input logic [31:0] p, input logic c);
    expq.push_back('{ins: ins, pc: p, c: c});
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic redirect_to(input logic [31:0] rp);
    tick;
    out_ready   = 1'b0;
    redirect_en = 1'b1;
    redirect_pc = rp;
    expq.delete();
  endtask

  task automatic settle(input int n);
    tick;
    redirect_en = 1'b0;
    out_ready   = 1'b1;
    repeat (n) tick;
  endtask

  task automatic rand_phase(input int n);
    int  h0;
    bit  b2b;
    logic [31:0] rp;
    h0  = handshakes;
    b2b = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick;
      if ($urandom_range(0, 29) == 0 || (b2b && $urandom_range(0, 2) == 0)) begin
        rp          = $urandom & (RVC ? ~32'h1 : ~32'h3);
        redirect_en = 1'b1;
        redirect_pc = rp;
        out_ready   = 1'b0;
        expq.delete();
        gen(rp, 400);
        b2b = 1'b1;
      end else begin
        redirect_en = 1'b0;
        out_ready   = $urandom_range(0, 3) != 0;
        b2b         = 1'b0;
      end
    end
    redirect_en = 1'b0;
    checks++;
    if (handshakes == h0) begin
      errors++;
      $display("FAIL progress: got 0 outputs in %0d cycles, required >0", n);
    end
  endtask

  // memory: random grant, in-order responses with random latency
  initial begin
    bit          p_stall;
    logic [31:0] p_addr;
    p_stall      = 1'b0;
    p_addr       = '0;
    fetch_gnt    = 1'b0;
    fetch_rvalid = 1'b0;
    fetch_rdata  = '0;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (p_stall) begin
        checks++;
        if (!fetch_req || fetch_addr !== p_addr) begin
          errors++;
          $display("FAIL fetch_hold: got req=%0b addr=%h, required req=1 addr=%h", fetch_req, fetch_addr, p_addr);
        end
      end
      if (fetch_req) begin
        checks++;
        if (pend.size() >= MAX_OUT || fetch_addr[1:0] != 2'b00) begin
          errors++;
          $display("FAIL fetch_limit: got outstanding=%0d addr=%h, required <%0d and word aligned", pend.size(), fetch_addr, MAX_OUT);
        end
      end
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        fetch_rvalid = 1'b1;
        fetch_rdata  = mem[pend[0].addr[11:2]];
        void'(pend.pop_front());
      end else begin
        fetch_rvalid = 1'b0;
        fetch_rdata  = $urandom;
      end
      fetch_gnt = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (fetch_req && fetch_gnt) pend.push_back('{addr: fetch_addr, due: cyc + 1 + $urandom_range(lat_lo, lat_hi)});
      p_stall = fetch_req && !fetch_gnt && !redirect_en;
      p_addr  = fetch_addr;
    end
  end

  // monitor: hold stability while stalled, scoreboard on every handshake
  initial begin
    bit          p_stall;
    logic [31:0] p_ins, p_pc;
    logic        p_c;
    exp_t        e;
    p_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (p_stall) begin
        checks++;
        if (!out_valid || instruction !== p_ins || pc !== p_pc || compflg !== p_c) begin
          errors++;
          $display("FAIL out_hold: got v=%0b ins=%h pc=%h c=%0b, required v=1 ins=%h pc=%h c=%0b",
                   out_valid, instruction, pc, compflg, p_ins, p_pc, p_c);
        end
      end
      p_stall = rst_n && out_valid && !out_ready && !redirect_en;
      p_ins   = instruction;
      p_pc    = pc;
      p_c     = compflg;
      if (rst_n && out_valid && out_ready) begin
        handshakes++;
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL scoreboard: got ins=%h pc=%h, required no output", instruction, pc);
        end else begin
          e = expq.pop_front();
          if (instruction !== e.ins || pc !== e.pc || compflg !== e.c) begin
            errors++;
            $display("FAIL scoreboard: got ins=%h pc=%h c=%0b, required ins=%h pc=%h c=%0b",
                     instruction, pc, compflg, e.ins, e.pc, e.c);
          end
        end
      end
    end
  end

  initial begin
    bit seen;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[0]          = 32'h0000_0013;
    mem[1]          = 32'h0000_0013;
    mem[32'h100>>2] = 32'h0000_0013;
    mem[32'h104>>2] = 32'h0000_0013;
    mem[32'h140>>2] = 32'h4505_FFFF;
    mem[32'h200>>2] = 32'h4501_4505;
    mem[32'h300>>2] = 32'h0093_4505;
    mem[32'h304>>2] = 32'hAAAA_0010;
    mem[1023]       = 32'h0000_0013;
    rst_n       = 1'b0;
    out_ready   = 1'b0;
    redirect_en = 1'b0;
    redirect_pc = '0;
    push_exp(32'h13, 32'h0, 1'b0);
    push_exp(32'h13, 32'h4, 1'b0);
    gen(32'h8, 400);
    repeat (3) tick;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_instruction", instruction, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_compflg", 32'(compflg), 32'h0);
    chk("rst_fetch_req", 32'(fetch_req), 32'h0);
    chk("rst_fetch_addr", fetch_addr, 32'h0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    // first response -> push cycle -> load cycle -> valid
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = fetch_rvalid;
    end
    chk("first_response_seen", 32'(seen), 32'h1);
    @(negedge clk);
    chk("latency_load_cycle", 32'(out_valid), 32'h0);
    @(negedge clk);
    chk("latency_valid", 32'(out_valid), 32'h1);
    repeat (20) tick;
    gnt_rand = 1'b1;
    lat_hi   = 3;
    rand_phase(300);
    // stall with the buffer filling
    gnt_rand  = 1'b0;
    lat_hi    = 0;
    out_ready = 1'b1;
    repeat (5) tick;
    out_ready = 1'b0;
    repeat (8) tick;
    chk("stall_fetch_req", 32'(fetch_req), 32'h0);
    chk("stall_out_valid", 32'(out_valid), 32'h1);
    out_ready = 1'b1;
    repeat (30) tick;
    // redirect with two responses in flight
    lat_lo = 4;
    lat_hi = 4;
    seen   = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick;
      seen = pend.size() == 2;
    end
    chk("two_outstanding", 32'(seen), 32'h1);
    redirect_to(32'h100);
    push_exp(32'h13, 32'h100, 1'b0);
    push_exp(32'h13, 32'h104, 1'b0);
    gen(32'h108, 400);
    tick;
    redirect_en = 1'b0;
    chk("redirect_fetch_addr", fetch_addr, 32'h100);
    chk("redirect_out_valid", 32'(out_valid), 32'h0);
    out_ready = 1'b1;
    repeat (40) tick;
    lat_lo = 0;
    lat_hi = 2;
`ifdef RVC_EN
    redirect_to(32'h142);
    push_exp(32'h4505, 32'h142, 1'b1);
    gen(32'h144, 400);
    settle(30);
    redirect_to(32'h200);
    push_exp(32'h4505, 32'h200, 1'b1);
    push_exp(32'h4501, 32'h202, 1'b1);
    gen(32'h204, 400);
    settle(30);
    redirect_to(32'h300);
    push_exp(32'h4505, 32'h300, 1'b1);
    push_exp(32'h0010_0093, 32'h302, 1'b0);
    gen(32'h306, 400);
    settle(30);
`else
    redirect_to(32'h140);
    push_exp(32'h4505_FFFF, 32'h140, 1'b0);
    gen(32'h144, 400);
    settle(30);
    redirect_to(32'h200);
    push_exp(32'h4501_4505, 32'h200, 1'b0);
    gen(32'h204, 400);
    settle(30);
    redirect_to(32'h300);
    push_exp(32'h0093_4505, 32'h300, 1'b0);
    push_exp(32'hAAAA_0010, 32'h304, 1'b0);
    gen(32'h308, 400);
    settle(30);
`endif
    // PC wrap across 2^32
    redirect_to(32'hFFFF_FFFC);
    push_exp(32'h13, 32'hFFFF_FFFC, 1'b0);
    push_exp(32'h13, 32'h0, 1'b0);
    gen(32'h4, 400);
    settle(30);
    // back-to-back redirects: the later one wins
    redirect_to(32'h300);
    tick;
    redirect_pc = 32'h100;
    expq.delete();
    push_exp(32'h13, 32'h100, 1'b0);
    gen(32'h104, 400);
    settle(30);
    gnt_rand = 1'b1;
    lat_hi   = 3;
    rand_phase(800);
    out_ready = 1'b1;
    repeat (10) tick;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
